// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, init-sequencer states and helpers.
// Used by the init sequencer and the SDRAM controller.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

    // Address bit that selects all banks during PRECHARGE.
    localparam int A10_BIT = 10;

    typedef enum logic [3:0] {
        ST_WAIT_PWR,
        ST_PRECHARGE,
        ST_WAIT_RP,
        ST_REFRESH,
        ST_WAIT_RFC,
        ST_LOAD_MODE,
        ST_WAIT_MRD,
        ST_DONE,
        ST_REINIT
    } init_state_e;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter that flags expiry at zero and then holds there.
// A load of (delay-1) on a command cycle expires exactly delay cycles later.
module sdram_wait_timer #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: power-up wait, PRECHARGE ALL, N AUTO REFRESH,
// LOAD MODE, then hands the bus downstream via initDone. Re-runnable from DONE.
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int                POWERUP_CYCLES = 12800,
    parameter int                T_RP           = 3,
    parameter int                T_RFC          = 8,
    parameter int                N_REFRESH      = 8,
    parameter int                T_MRD          = 2,
    parameter int                ADDR_W         = 11,
    parameter int                BA_W           = 2,
    parameter logic [ADDR_W-1:0] MODE_REG       = 11'h020
) (
    input  logic              clk,
    input  logic              rstIn,
    input  logic              reinitReq,
    output logic              sdrCke,
    output logic [3:0]        sdrCmd,
    output logic [ADDR_W-1:0] sdrAddr,
    output logic [BA_W-1:0]   sdrBa,
    output logic              initDone,
    output logic              busy
);

    localparam int TMR_W = $clog2(max_of4(POWERUP_CYCLES, T_RFC, T_RP, T_MRD) + 1);
    localparam int REF_W = $clog2(N_REFRESH + 1);

    localparam logic [TMR_W-1:0] LD_RP  = TMR_W'(T_RP - 1);
    localparam logic [TMR_W-1:0] LD_RFC = TMR_W'(T_RFC - 1);
    localparam logic [TMR_W-1:0] LD_MRD = TMR_W'(T_MRD - 1);
    // Power-up count uses the same delay-1 convention, so PRECHARGE lands on cycle POWERUP_CYCLES.
    localparam logic [TMR_W-1:0] LD_PWR = TMR_W'(POWERUP_CYCLES - 1);

    if (POWERUP_CYCLES < 1 || T_RP < 1 || T_RFC < 1 || T_MRD < 1) begin : g_bad_timing
        $error("sdram_init_seq: timing parameters must be at least 1");
    end
    if (N_REFRESH < 2) begin : g_bad_nref
        $error("sdram_init_seq: N_REFRESH must be at least 2");
    end
    if (ADDR_W <= A10_BIT) begin : g_bad_addr
        $error("sdram_init_seq: ADDR_W too narrow for the precharge-all bit");
    end

    init_state_e       state_q, state_d;
    logic [REF_W-1:0]  ref_q, ref_d;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired;

    logic              cke_q, cke_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    sdram_wait_timer #(
        .W       (TMR_W),
        .RST_VAL (LD_PWR)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rstIn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    // Command states fall through to their wait state; both check expiry so a delay of 1 works.
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_WAIT_PWR: begin
                if (tmr_expired) begin
                    state_d  = ST_PRECHARGE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RP;
                end
            end
            ST_PRECHARGE, ST_WAIT_RP: begin
                state_d = ST_WAIT_RP;
                if (tmr_expired) begin
                    state_d  = ST_REFRESH;
                    ref_d    = REF_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = LD_RFC;
                end
            end
            ST_REFRESH, ST_WAIT_RFC: begin
                state_d = ST_WAIT_RFC;
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    if (ref_q == REF_W'(N_REFRESH)) begin
                        state_d = ST_LOAD_MODE;
                        tmr_val = LD_MRD;
                    end else begin
                        state_d = ST_REFRESH;
                        ref_d   = ref_q + REF_W'(1);
                        tmr_val = LD_RFC;
                    end
                end
            end
            ST_LOAD_MODE, ST_WAIT_MRD: begin
                state_d = tmr_expired ? ST_DONE : ST_WAIT_MRD;
            end
            ST_DONE: begin
                if (reinitReq) begin
                    state_d = ST_REINIT;
                end
            end
            ST_REINIT: begin
                state_d  = ST_PRECHARGE;
                tmr_load = 1'b1;
                tmr_val  = LD_RP;
            end
            default: begin
                state_d = ST_WAIT_PWR;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        cke_d  = 1'b1;
        cmd_d  = CMD_NOP;
        addr_d = '0;
        ba_d   = '0;
        done_d = 1'b0;
        busy_d = 1'b1;
        case (state_d)
            ST_PRECHARGE: begin
                cmd_d           = CMD_PRECHARGE;
                addr_d[A10_BIT] = 1'b1;
            end
            ST_REFRESH:   cmd_d = CMD_REFRESH;
            ST_LOAD_MODE: begin
                cmd_d  = CMD_LOAD_MODE;
                addr_d = MODE_REG;
            end
            ST_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            state_q <= ST_WAIT_PWR;
            ref_q   <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_INHIBIT;
            addr_q  <= '0;
            ba_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            ba_q    <= ba_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sdrCke   = cke_q;
    assign sdrCmd   = cmd_q;
    assign sdrAddr  = addr_q;
    assign sdrBa    = ba_q;
    assign initDone = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: fixed timeline vectors, reset/re-init corner cases,
// and random reinit/reset traffic against a schedule-based reference model.
module tb_sdram_init_seq;

    localparam int P    = 20;
    localparam int TRP  = 3;
    localparam int TRFC = 8;
    localparam int NREF = 2;
    localparam int TMRD = 2;
    localparam int VW   = 20;

    localparam logic [3:0]  C_NOP  = 4'b0111;
    localparam logic [3:0]  C_PRE  = 4'b0010;
    localparam logic [3:0]  C_REF  = 4'b0001;
    localparam logic [3:0]  C_LMR  = 4'b0000;
    localparam logic [10:0] A_PALL = 11'h400;
    localparam logic [10:0] A_MODE = 11'h020;
    // {cke, cmd, addr, ba, initDone, busy} while in reset
    localparam logic [VW-1:0] RST_VEC = {1'b0, 4'b1111, 11'h000, 2'b00, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst_in;
    logic        reinit_req;
    logic        sdr_cke;
    logic [3:0]  sdr_cmd;
    logic [10:0] sdr_addr;
    logic [1:0]  sdr_ba;
    logic        init_done;
    logic        busy;
    logic [VW-1:0] dut_vec;

    always #5 clk = ~clk;

    sdram_init_seq #(
        .POWERUP_CYCLES (P),
        .T_RP           (TRP),
        .T_RFC          (TRFC),
        .N_REFRESH      (NREF),
        .T_MRD          (TMRD),
        .ADDR_W         (11),
        .BA_W           (2),
        .MODE_REG       (A_MODE)
    ) dut (
        .clk       (clk),
        .rstIn     (rst_in),
        .reinitReq (reinit_req),
        .sdrCke    (sdr_cke),
        .sdrCmd    (sdr_cmd),
        .sdrAddr   (sdr_addr),
        .sdrBa     (sdr_ba),
        .initDone  (init_done),
        .busy      (busy)
    );

    assign dut_vec = {sdr_cke, sdr_cmd, sdr_addr, sdr_ba, init_done, busy};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;  // cycle number since the last reset release
    int base   = P;  // cycle on which the current run's PRECHARGE lands
    logic [VW-1:0] exp_q[$];

    typedef struct {
        int            cyc;
        logic          req;
        logic [VW-1:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [VW-1:0] pack(input logic [3:0] cmd, input logic [10:0] addr,
                                           input logic done);
        return {1'b1, cmd, addr, 2'b00, done, ~done};
    endfunction

    // Reference schedule: everything follows from the PRECHARGE cycle b.
    function automatic logic done_at(input int c, input int b);
        return c >= b + TRP + NREF * TRFC + TMRD;
    endfunction

    function automatic logic [VW-1:0] model_out(input int c, input int b);
        int lm;
        lm = b + TRP + NREF * TRFC;
        if (c == b) return pack(C_PRE, A_PALL, 1'b0);
        if (c == lm) return pack(C_LMR, A_MODE, 1'b0);
        if (c >= b + TRP && c < lm && ((c - b - TRP) % TRFC) == 0) return pack(C_REF, 11'h0, 1'b0);
        return pack(C_NOP, 11'h0, done_at(c, b));
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_in) begin
            cyc++;
            if (done_at(cyc - 1, base) && reinit_req) base = cyc + 1;
            exp_q.push_back(model_out(cyc, base));
        end else begin
            exp_q.push_back(RST_VEC);
        end
        @(negedge clk);
        check("model", dut_vec, exp_q.pop_front());
    endtask

    task automatic release_rst();
        rst_in = 1'b1;
        cyc    = 0;
        base   = P;
    endtask

    task automatic add(input int c, input logic r, input logic [VW-1:0] e);
        vec_t v;
        v.cyc = c;
        v.req = r;
        v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int nref;
        int run;
        int pulses;

        // Timeline of the first run, with a mid-sequence reinit pulse and a later one in DONE.
        add(1,  1'b0, pack(C_NOP, 11'h0,  1'b0));
        add(19, 1'b0, pack(C_NOP, 11'h0,  1'b0));
        add(20, 1'b0, pack(C_PRE, A_PALL, 1'b0));
        add(21, 1'b0, pack(C_NOP, 11'h0,  1'b0));
        add(22, 1'b0, pack(C_NOP, 11'h0,  1'b0));
        add(23, 1'b0, pack(C_REF, 11'h0,  1'b0));
        add(24, 1'b1, pack(C_NOP, 11'h0,  1'b0));
        add(25, 1'b0, pack(C_NOP, 11'h0,  1'b0));
        add(30, 1'b0, pack(C_NOP, 11'h0,  1'b0));
        add(31, 1'b0, pack(C_REF, 11'h0,  1'b0));
        add(38, 1'b0, pack(C_NOP, 11'h0,  1'b0));
        add(39, 1'b0, pack(C_LMR, A_MODE, 1'b0));
        add(40, 1'b0, pack(C_NOP, 11'h0,  1'b0));
        add(41, 1'b0, pack(C_NOP, 11'h0,  1'b1));
        add(50, 1'b1, pack(C_NOP, 11'h0,  1'b1));
        add(51, 1'b0, pack(C_NOP, 11'h0,  1'b0));
        add(52, 1'b0, pack(C_PRE, A_PALL, 1'b0));
        add(55, 1'b0, pack(C_REF, 11'h0,  1'b0));
        add(63, 1'b0, pack(C_REF, 11'h0,  1'b0));
        add(71, 1'b0, pack(C_LMR, A_MODE, 1'b0));
        add(72, 1'b0, pack(C_NOP, 11'h0,  1'b0));
        add(73, 1'b0, pack(C_NOP, 11'h0,  1'b1));

        rst_in     = 1'b0;
        reinit_req = 1'b0;
        repeat (3) tick();
        check("reset", dut_vec, RST_VEC);
        release_rst();

        foreach (tbl[i]) begin
            while (cyc < tbl[i].cyc) tick();
            check($sformatf("vec@%0d", tbl[i].cyc), dut_vec, tbl[i].exp);
            reinit_req = tbl[i].req;
        end

        // Reset between the two refreshes, then a full clean restart.
        rst_in = 1'b0;
        tick();
        release_rst();
        while (cyc < 27) tick();
        #2;
        rst_in = 1'b0;
        #1;
        check("async_rst", dut_vec, RST_VEC);
        repeat (2) tick();
        release_rst();
        nref = 0;
        repeat (45) begin
            tick();
            if (sdr_cmd == C_REF) nref++;
        end
        check("refresh_count", VW'(nref), VW'(NREF));

        // Continuous reinit request: back-to-back runs with one-cycle initDone pulses.
        reinit_req = 1'b1;
        run        = 0;
        pulses     = 0;
        repeat (80) begin
            tick();
            if (init_done) begin
                run++;
            end else if (run > 0) begin
                check("done_pulse", VW'(run), VW'(1));
                pulses++;
                run = 0;
            end
        end
        check("pulse_count", VW'(pulses >= 3), VW'(1));
        reinit_req = 1'b0;

        // Random reinit requests and occasional asynchronous resets.
        repeat (700) begin
            reinit_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 249) == 0) begin
                rst_in = 1'b0;
                #1;
                check("async_rst_rand", dut_vec, RST_VEC);
                repeat ($urandom_range(1, 3)) tick();
                release_rst();
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
